conv2d_3x3_stream: RTL and testbench

//  Streaming 3x3 FP32 convolution over a raster-scan image of IMG_W x IMG_H pixels, one pixel per valid_in beat.

---
 rtl/conv2d_3x3_stream_pkg.sv | 119 +++++++++++
 rtl/conv2d_3x3_stream_if.sv | 23 ++
 rtl/conv2d_3x3_stream_window.sv | 77 +++++++
 rtl/conv2d_3x3_stream.sv | 77 +++++++
 tb/tb_conv2d_3x3_stream.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_3x3_stream_pkg.sv
// Shared constants and FP32 arithmetic for the streaming 3x3 convolution.
// Contents: FP32 literals, kernel geometry, pipeline depth, default Sobel-X kernel,
//           fp_mul / fp_add (round-to-nearest-even, subnormals flushed to zero).
package conv2d_3x3_stream_pkg;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
  localparam logic [31:0] FP_TWO     = 32'h4000_0000;
  localparam logic [31:0] FP_NEG_TWO = 32'hC000_0000;

  localparam int KERNEL_TAPS = 9;
  localparam int TREE_LEVELS = 4;
  localparam int PIPE_LAT    = 5;

  // w0 sits in the low word, w8 in the high word.
  localparam logic [KERNEL_TAPS*32-1:0] SOBEL_X = {
    FP_NEG_ONE, FP_ZERO, FP_ONE,
    FP_NEG_TWO, FP_ZERO, FP_TWO,
    FP_NEG_ONE, FP_ZERO, FP_ONE
  };

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [23:0] m;
    logic        g;
    logic        st;
    logic [24:0] rnd;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    rnd = {1'b0, m} + ((g && (st || m[0])) ? 25'd1 : 25'd0);
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 1;
    end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), rnd[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    logic [31:0] y;
    logic [26:0] mx;
    logic [26:0] my;
    logic [26:0] ms;
    logic [27:0] sum;
    logic [7:0]  d;
    logic [24:0] rnd;
    logic        found;
    int          er;
    int          lz;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    // x is the larger magnitude, so a subtraction never goes negative
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    if (d > 8'd26) begin
      ms = 27'd1;
    end else begin
      ms    = my >> d;
      ms[0] = ms[0] | (|(my & ((27'd1 << d) - 27'd1)));
    end
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, ms};
    else                sum = {1'b0, mx} - {1'b0, ms};
    if (sum == 28'd0) return 32'd0;  // exact cancellation gives +0
    er = int'(x[30:23]);
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      er  = er + 1;
    end else begin
      lz    = 0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else        lz = lz + 1;
        end
      end
      sum = sum << lz;
      er  = er - lz;
      if (er <= 0) return {x[31], 31'd0};
    end
    rnd = {1'b0, sum[26:3]} + ((sum[2] && (sum[1] || sum[0] || sum[3])) ? 25'd1 : 25'd0);
    if (rnd[24]) begin
      rnd = rnd >> 1;
      er  = er + 1;
    end
    if (er >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], 8'(er), rnd[22:0]};
  endfunction

endpackage

// File: rtl/conv2d_3x3_stream_if.sv
// Pixel stream in, weight write port, and result stream out of the 3x3 convolver.
// master: pixel source / weight loader side. slave: the convolver.
// Signals: valid_in, data_in, w_we, w_addr, w_data, valid_out, data_out, eof_out.
interface conv2d_3x3_stream_if;
  logic        valid_in;
  logic [31:0] data_in;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic        valid_out;
  logic [31:0] data_out;
  logic        eof_out;

  modport master (
    output valid_in, data_in, w_we, w_addr, w_data,
    input  valid_out, data_out, eof_out
  );

  modport slave (
    input  valid_in, data_in, w_we, w_addr, w_data,
    output valid_out, data_out, eof_out
  );
endinterface

// File: rtl/conv2d_3x3_stream_window.sv
// Sliding 3x3 window over a raster stream: two line buffers, 9 window regs, row/col counters.
// Ports: Clk, Rst, valid_in, data_in in; taps (w0 order, oldest first), win_valid, win_eof out.
// Everything shifts only on valid_in; win_valid/win_eof pulse the cycle after a completing pixel.
module conv3x3_window
  import conv2d_3x3_stream_pkg::*;
#(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          valid_in,
  input  logic [31:0]                   data_in,
  output logic [KERNEL_TAPS-1:0][31:0]  taps,
  output logic                          win_valid,
  output logic                          win_eof
);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  // Three window columns plus LB_D buffer entries make exactly one row of delay.
  localparam int LB_D = IMG_W - 3;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [31:0]   win [3][3];  // win[0] oldest row, win[x][0] oldest column
  logic [31:0]   lb1 [LB_D];  // feeds the middle window row
  logic [31:0]   lb2 [LB_D];  // feeds the top window row

  always_ff @(posedge Clk) begin
    if (Rst) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_eof   <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      // Only windows fully inside one frame row band produce a result.
      win_valid <= valid_in && (row >= RW'(2)) && (col >= CW'(2));
      win_eof   <= valid_in && (row == ROW_LAST) && (col == COL_LAST);
      if (valid_in) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[2][2] <= data_in;
        win[1][2] <= lb1[LB_D-1];
        win[0][2] <= lb2[LB_D-1];
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Line buffer contents are don't-care after reset: border windows are suppressed.
  always_ff @(posedge Clk) begin
    if (valid_in) begin
      lb1[0] <= win[2][0];
      lb2[0] <= win[1][0];
      for (int i = 1; i < LB_D; i++) begin
        lb1[i] <= lb1[i-1];
        lb2[i] <= lb2[i-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < KERNEL_TAPS; i++) taps[i] = win[i/3][i%3];
  end
endmodule

// File: rtl/conv2d_3x3_stream.sv
// Streaming 3x3 FP32 convolution with runtime-loadable weights and end-of-frame marking.
// Ports: Clk, Rst (sync, active high), bus (slave): pixel in, weight write, result out.
// Latency 5 cycles from accepting edge to valid_out; pipeline free-runs, data_out holds between results.
module conv2d_3x3_stream
  import conv2d_3x3_stream_pkg::*;
#(
  parameter int                          DATA_WIDTH = 32,
  parameter int                          IMG_W      = 100,
  parameter int                          IMG_H      = 100,
  parameter logic [KERNEL_TAPS*32-1:0]   W_INIT     = SOBEL_X
) (
  input  logic                 Clk,
  input  logic                 Rst,
  conv2d_3x3_stream_if.slave   bus
);
  logic [KERNEL_TAPS-1:0][31:0] taps;
  logic                         win_valid;
  logic                         win_eof;

  logic [DATA_WIDTH-1:0] wt [KERNEL_TAPS];
  logic [DATA_WIDTH-1:0] s1 [KERNEL_TAPS];  // products
  logic [DATA_WIDTH-1:0] s2 [5];
  logic [DATA_WIDTH-1:0] s3 [3];
  logic [DATA_WIDTH-1:0] s4 [2];
  logic [TREE_LEVELS:1]  vld;  // valid bit alongside s1..s4
  logic [TREE_LEVELS:1]  eof;

  conv3x3_window #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_window (
    .Clk       (Clk),
    .Rst       (Rst),
    .valid_in  (bus.valid_in),
    .data_in   (bus.data_in),
    .taps      (taps),
    .win_valid (win_valid),
    .win_eof   (win_eof)
  );

  // A write at edge t is seen by the multiplies sampled at t+1 onward.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < KERNEL_TAPS; i++) wt[i] <= W_INIT[i*32 +: 32];
    end else if (bus.w_we && (bus.w_addr < 4'(KERNEL_TAPS))) begin
      wt[bus.w_addr] <= bus.w_data;
    end
  end

  // Datapath: 9 multiplies, then the fixed 9->5->3->2->1 adder tree; odd lanes pass through.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < KERNEL_TAPS; i++) s1[i] <= fp_mul(taps[i], wt[i]);
    for (int i = 0; i < 4; i++) s2[i] <= fp_add(s1[2*i], s1[2*i+1]);
    s2[4] <= s1[8];
    s3[0] <= fp_add(s2[0], s2[1]);
    s3[1] <= fp_add(s2[2], s2[3]);
    s3[2] <= s2[4];
    s4[0] <= fp_add(s3[0], s3[1]);
    s4[1] <= s3[2];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld           <= '0;
      eof           <= '0;
      bus.valid_out <= 1'b0;
      bus.eof_out   <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      vld           <= {vld[TREE_LEVELS-1:1], win_valid};
      eof           <= {eof[TREE_LEVELS-1:1], win_eof};
      bus.valid_out <= vld[TREE_LEVELS];
      bus.eof_out   <= vld[TREE_LEVELS] & eof[TREE_LEVELS];
      if (vld[TREE_LEVELS]) bus.data_out <= fp_add(s4[0], s4[1]);
    end
  end
endmodule

// File: tb/tb_conv2d_3x3_stream.sv
module tb_conv2d_3x3_stream;
  localparam int W   = 5;
  localparam int H   = 5;
  localparam int LAT = 5;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        eof;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  conv2d_3x3_stream_if bus();

  conv2d_3x3_stream #(.DATA_WIDTH(32), .IMG_W(W), .IMG_H(H)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          res_cnt = 0;
  int          eof_cnt = 0;
  int          wm [9];
  exp_t        sb [$];
  logic        in_rst = 1'b1;
  logic [31:0] last_data = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] to_fp(input int v);
    logic [31:0] mag;
    logic [31:0] tmp;
    int          e;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    e = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) e = i;
    tmp = mag << (23 - e);
    return {v < 0, 8'(127 + e), tmp[22:0]};
  endfunction

  function automatic int pixval(input int mode, input int r, input int c);
    return (mode == 0) ? c : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (!in_rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        chk("missed_result_cycle", 32'(cyc), 32'(e.due));
      end
      if (bus.valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'd0, bus.valid_out}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("data", bus.data_out, e.data);
          chk("eof", {31'd0, bus.eof_out}, {31'd0, e.eof});
          chk("latency", 32'(cyc), 32'(e.due));
          res_cnt++;
          if (bus.eof_out) eof_cnt++;
        end
      end else begin
        chk("eof_idle", {31'd0, bus.eof_out}, 32'd0);
        chk("hold", bus.data_out, last_data);
      end
    end
    last_data = bus.data_out;
  end

  task automatic push_pixel(input int r, input int c, input int mode,
                            input logic we, input logic [3:0] wa, input int wv);
    exp_t e;
    int   s;
    bus.valid_in = 1'b1;
    bus.data_in  = to_fp(pixval(mode, r, c));
    bus.w_we     = we;
    bus.w_addr   = wa;
    bus.w_data   = to_fp(wv);
    if (we && wa < 4'd9) wm[wa] = wv;
    if (r >= 2 && c >= 2) begin
      s = 0;
      for (int i = 0; i < 9; i++) s += wm[i] * pixval(mode, r - 2 + i / 3, c - 2 + i % 3);
      e.due  = cyc + 1 + LAT;
      e.data = to_fp(s);
      e.eof  = (r == H - 1) && (c == W - 1);
      sb.push_back(e);
    end
    @(posedge Clk); #1;
    bus.w_we = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    bus.w_we     = 1'b0;
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic run_frame(input int mode, input int gap, input int wr_k,
                           input logic [3:0] wa, input int wv);
    for (int k = 0; k < W * H; k++) begin
      push_pixel(k / W, k % W, mode, k == wr_k, wa, wv);
      if (gap != 0) idle(1);
    end
  endtask

  task automatic write_w(input logic [3:0] wa, input int wv);
    bus.valid_in = 1'b0;
    bus.w_we     = 1'b1;
    bus.w_addr   = wa;
    bus.w_data   = to_fp(wv);
    if (wa < 4'd9) wm[wa] = wv;
    @(posedge Clk); #1;
    bus.w_we = 1'b0;
  endtask

  task automatic sobel_model();
    wm = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int e0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.w_we     = 1'b0;
    bus.w_addr   = '0;
    bus.w_data   = '0;
    sobel_model();

    // Reset state
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_data_out", bus.data_out, 32'd0);
    chk("rst_eof_out", {31'd0, bus.eof_out}, 32'd0);
    @(posedge Clk); #1;
    in_rst = 1'b0;

    // Sobel-X, pixel = col: nine results of -8, eof on the ninth
    r0 = res_cnt; e0 = eof_cnt;
    run_frame(0, 0, -1, 4'd0, 0);
    idle(LAT + 3);
    chk("t1_count", 32'(res_cnt - r0), 32'd9);
    chk("t1_eof_count", 32'(eof_cnt - e0), 32'd1);
    chk("t1_last_value", bus.data_out, 32'hC100_0000);

    // Sobel-X, pixel = row: all zero
    run_frame(1, 0, -1, 4'd0, 0);
    idle(LAT + 3);
    chk("t2_last_value", bus.data_out, 32'h0000_0000);

    // All-ones kernel, pixel = col: 9, 18, 27 by centre column
    for (int i = 0; i < 9; i++) write_w(4'(i), 1);
    run_frame(0, 0, -1, 4'd0, 0);
    idle(LAT + 3);
    chk("t3_last_value", bus.data_out, 32'h41D8_0000);

    // Reset after 12 pixels: outputs clear, weights return to Sobel-X
    for (int k = 0; k < 12; k++) push_pixel(k / W, k % W, 0, 1'b0, 4'd0, 0);
    in_rst = 1'b1;
    bus.valid_in = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("mid_rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
    chk("mid_rst_data_out", bus.data_out, 32'd0);
    chk("mid_rst_queue", 32'(sb.size()), 32'd0);
    sobel_model();
    @(posedge Clk); #1;
    in_rst = 1'b0;
    r0 = res_cnt;
    run_frame(0, 0, -1, 4'd0, 0);
    idle(LAT + 3);
    chk("t5_count", 32'(res_cnt - r0), 32'd9);

    // Alternating valid_in: same values, latency measured from each completing pixel
    r0 = res_cnt;
    run_frame(0, 1, -1, 4'd0, 0);
    idle(LAT + 3);
    chk("t6_count", 32'(res_cnt - r0), 32'd9);

    // Out-of-range weight address is ignored
    run_frame(0, 0, 7, 4'd9, 2);
    idle(LAT + 3);
    chk("t7_last_value", bus.data_out, 32'hC100_0000);

    // Back-to-back frames; second one rewrites w4 together with pixel (2,2)
    r0 = res_cnt; e0 = eof_cnt;
    run_frame(0, 0, -1, 4'd0, 0);
    run_frame(0, 0, 12, 4'd4, 1);
    idle(LAT + 3);
    chk("t8_count", 32'(res_cnt - r0), 32'd18);
    chk("t8_eof_count", 32'(eof_cnt - e0), 32'd2);
    chk("t8_last_value", bus.data_out, 32'hC0A0_0000);

    chk("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
